// File: rtl/pulse_width_meter_pkg.sv
// Shared definitions for pulse_width_meter and its sibling Counter block:
// FSM state encoding, default width limit and the counter-width helper.
package pulse_width_meter_pkg;

    // Default largest measurable width; Counter uses the same limit.
    localparam int DEFAULT_MAX_N       = 255;
    localparam int DEFAULT_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    // Bits needed to hold values 0..max_n inclusive.
    function automatic int ctr_size(input int max_n);
        return (max_n < 1) ? 1 : $clog2(max_n + 1);
    endfunction

endpackage

// File: rtl/pulse_width_meter_if.sv
// Control/result bundle of pulse_width_meter.
//
// Handshake: start is a one-cycle request with no ready; the meter only
// accepts it in IDLE or DONE and ignores it elsewhere (busy tells the
// requester when it would be ignored). done_sig is a one-cycle valid with
// no back-pressure; meas_val and overflow are valid in that cycle and then
// hold until the next accepted start.
interface pulse_width_meter_if #(
    parameter int MAX_N = pulse_width_meter_pkg::DEFAULT_MAX_N
);
    localparam int CTR_SIZE = pulse_width_meter_pkg::ctr_size(MAX_N);

    logic                start;
    logic                sig_in;
    logic [CTR_SIZE-1:0] meas_val;
    logic                done_sig;
    logic                busy;
    logic                overflow;

    // Requester side: arms the meter and supplies the line to measure.
    modport master (
        output start,
        output sig_in,
        input  meas_val,
        input  done_sig,
        input  busy,
        input  overflow
    );

    // Meter side.
    modport slave (
        input  start,
        input  sig_in,
        output meas_val,
        output done_sig,
        output busy,
        output overflow
    );

endinterface

// File: rtl/pulse_width_meter_edge_sync.sv
// edge_sync: SYNC_STAGES-deep synchronizer for an asynchronous line plus one
// history flop for edge detection. Legal SYNC_STAGES range is 2..4.
// Reusable by the other bus-sniffing blocks.
module edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic s_q,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   s_prev;

    // Shift the raw line through the synchronizer and keep one cycle of history.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_ff <= '0;
            s_prev  <= 1'b0;
        end else begin
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], d};
            s_prev  <= sync_ff[SYNC_STAGES-1];
        end
    end

    assign s_q  = sync_ff[SYNC_STAGES-1];
    assign rise = s_q & ~s_prev;
    assign fall = ~s_q & s_prev;

endmodule

// File: rtl/pulse_width_meter.sv
// pulse_width_meter: arms on start, waits for a rising edge on the
// asynchronous sig_in, counts sys_clk cycles while it stays high and
// reports the width with a one-cycle done_sig. Widths of MAX_N or more
// saturate at MAX_N with overflow set.
// Optional feature macro: PULSE_WIDTH_METER_TIMEOUT_EN -- ARM gives up after
// MAX_N cycles without a rise and reports meas_val=0 with overflow=1.
module pulse_width_meter
    import pulse_width_meter_pkg::*;
#(
    parameter int MAX_N       = DEFAULT_MAX_N,
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic                      sys_clk,
    input  logic                      rst,
    pulse_width_meter_if.slave        bus,
    output state_t                    state_dbg
);

    localparam int CTR_SIZE = ctr_size(MAX_N);
    localparam logic [CTR_SIZE-1:0] MAX_VAL  = CTR_SIZE'(MAX_N);
    localparam logic [CTR_SIZE-1:0] LAST_VAL = CTR_SIZE'(MAX_N - 1);
    localparam logic [CTR_SIZE-1:0] ONE      = CTR_SIZE'(1);

    state_t              state;
    logic [CTR_SIZE-1:0] counter;
    logic [CTR_SIZE-1:0] meas_val;
    logic                done_sig;
    logic                busy;
    logic                overflow;

    logic s_q;
    logic rise;
    logic fall;

    edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge_sync (
        .clk  (sys_clk),
        .rst  (rst),
        .d    (bus.sig_in),
        .s_q  (s_q),
        .rise (rise),
        .fall (fall)
    );

    // Measurement FSM with registered outputs. The saturation check fires
    // on the MAX_N-th high cycle (counter already at MAX_N-1 and the line
    // still high), so a pulse of exactly MAX_N cycles reports overflow.
    // In ARM the counter doubles as the timeout wait counter when enabled.
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            counter  <= '0;
            meas_val <= '0;
            done_sig <= 1'b0;
            busy     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            done_sig <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state    <= ARM;
                        counter  <= '0;
                        meas_val <= '0;
                        overflow <= 1'b0;
                        busy     <= 1'b1;
                    end
                end

                ARM: begin
                    if (rise) begin
                        if (MAX_N == 1) begin
                            state    <= DONE;
                            meas_val <= MAX_VAL;
                            overflow <= 1'b1;
                            done_sig <= 1'b1;
                            busy     <= 1'b0;
                        end else begin
                            state   <= MEASURE;
                            counter <= ONE;
                        end
                    end
`ifdef PULSE_WIDTH_METER_TIMEOUT_EN
                    else if (counter == LAST_VAL) begin
                        state    <= DONE;
                        meas_val <= '0;
                        overflow <= 1'b1;
                        done_sig <= 1'b1;
                        busy     <= 1'b0;
                    end else begin
                        counter <= counter + ONE;
                    end
`endif
                end

                MEASURE: begin
                    if (!s_q) begin
                        state    <= DONE;
                        meas_val <= counter;
                        done_sig <= 1'b1;
                        busy     <= 1'b0;
                    end else if (counter == LAST_VAL) begin
                        state    <= DONE;
                        counter  <= MAX_VAL;
                        meas_val <= MAX_VAL;
                        overflow <= 1'b1;
                        done_sig <= 1'b1;
                        busy     <= 1'b0;
                    end else begin
                        counter <= counter + ONE;
                    end
                end

                DONE: begin
                    if (bus.start) begin
                        state    <= ARM;
                        counter  <= '0;
                        meas_val <= '0;
                        overflow <= 1'b0;
                        busy     <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.meas_val = meas_val;
    assign bus.done_sig = done_sig;
    assign bus.busy     = busy;
    assign bus.overflow = overflow;
    assign state_dbg    = state;

    // Falling-edge strobe is not needed here; it exists for other users of edge_sync.
    logic unused_fall;
    assign unused_fall = fall;

endmodule

// File: tb/tb_pulse_width_meter.sv
// Directed bench for pulse_width_meter (MAX_N=9, SYNC_STAGES=2).
// Expected {overflow, meas_val} results are queued when a measurement is
// issued; a monitor pops and compares on every done_sig.
module tb_pulse_width_meter;
    import pulse_width_meter_pkg::*;

    localparam int MAX_N = 9;
    localparam int W     = 4;

    logic   clk;
    logic   rst;
    state_t state_dbg;

    int vectors     = 0;
    int miscompares = 0;
    logic [W:0] exp_q[$];
    logic prev_done = 1'b0;

    pulse_width_meter_if #(.MAX_N(MAX_N)) bus ();

    pulse_width_meter #(
        .MAX_N       (MAX_N),
        .SYNC_STAGES (2)
    ) dut (
        .sys_clk   (clk),
        .rst       (rst),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // Clock and watchdog.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic pulse(input int n);
        bus.sig_in = 1'b1;
        repeat (n) @(negedge clk);
        bus.sig_in = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cyc);
        cyc = 0;
        while (!bus.done_sig && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        check("done_within_budget", int'(bus.done_sig), 1);
    endtask

    // Scoreboard monitor: every done_sig must match the oldest expectation.
    always @(negedge clk) begin
        if (rst && bus.done_sig) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_done: meas_val=%0d overflow=%0d, expected no done",
                         bus.meas_val, bus.overflow);
            end else begin
                logic [W:0] e;
                e = exp_q.pop_front();
                check("meas_val", int'(bus.meas_val), int'(e[W-1:0]));
                check("overflow", int'(bus.overflow), int'(e[W]));
                check("busy_low_at_done", int'(bus.busy), 0);
                check("done_one_cycle", int'(prev_done), 0);
            end
        end
        prev_done <= bus.done_sig;
    end

    // Directed stimulus.
    initial begin
        int cyc;
        int busy_drops;

        rst        = 1'b0;
        bus.start  = 1'b0;
        bus.sig_in = 1'b0;
        tick(3);
        check("rst_meas_val", int'(bus.meas_val), 0);
        check("rst_done", int'(bus.done_sig), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_overflow", int'(bus.overflow), 0);
        check("rst_state", int'(state_dbg), int'(IDLE));
        rst = 1'b1;
        tick(2);

        // 7-cycle pulse: result 3 cycles after the fall.
        exp_q.push_back({1'b0, 4'd7});
        do_start();
        check("t1_busy_armed", int'(bus.busy), 1);
        check("t1_state_arm", int'(state_dbg), int'(ARM));
        pulse(7);
        wait_done(20, cyc);
        check("t1_latency", cyc, 3);
        tick(1);
        check("t1_busy_after", int'(bus.busy), 0);
        check("t1_state_idle", int'(state_dbg), int'(IDLE));
        check("t1_meas_hold", int'(bus.meas_val), 7);
        tick(2);

        // Long pulse saturates while still high; restart accepted in DONE,
        // then the ongoing high is ignored and a fresh 3-cycle pulse measured.
        exp_q.push_back({1'b1, 4'd9});
        bus.sig_in = 1'b1;
        do_start();
        wait_done(40, cyc);
        exp_q.push_back({1'b0, 4'd3});
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
        check("t2_restart_busy", int'(bus.busy), 1);
        check("t2_restart_state", int'(state_dbg), int'(ARM));
        check("t2_meas_cleared", int'(bus.meas_val), 0);
        check("t2_ovf_cleared", int'(bus.overflow), 0);
        tick(4);
        bus.sig_in = 1'b0;
        tick(3);
        pulse(3);
        wait_done(20, cyc);
        tick(2);

        // Line already high at arm time: partial pulse ignored.
        bus.sig_in = 1'b1;
        tick(4);
        exp_q.push_back({1'b0, 4'd3});
        do_start();
        tick(3);
        bus.sig_in = 1'b0;
        tick(3);
        pulse(3);
        wait_done(20, cyc);
        tick(2);

        // Boundaries: MAX_N-1 is exact, MAX_N saturates.
        exp_q.push_back({1'b0, 4'd8});
        do_start();
        pulse(8);
        wait_done(20, cyc);
        tick(2);
        exp_q.push_back({1'b1, 4'd9});
        do_start();
        pulse(9);
        wait_done(20, cyc);
        tick(2);

        // Reset two cycles into MEASURE: outputs clear at once, no done.
        do_start();
        bus.sig_in = 1'b1;
        cyc = 0;
        while (state_dbg != MEASURE && cyc < 10) begin
            tick(1);
            cyc++;
        end
        check("t4_reached_measure", int'(state_dbg), int'(MEASURE));
        tick(2);
        rst = 1'b0;
        #1;
        check("t4_rst_meas", int'(bus.meas_val), 0);
        check("t4_rst_busy", int'(bus.busy), 0);
        check("t4_rst_ovf", int'(bus.overflow), 0);
        check("t4_rst_done", int'(bus.done_sig), 0);
        check("t4_rst_state", int'(state_dbg), int'(IDLE));
        bus.sig_in = 1'b0;
        tick(2);
        rst = 1'b1;
        tick(3);
        exp_q.push_back({1'b0, 4'd5});
        do_start();
        pulse(5);
        wait_done(20, cyc);
        tick(2);

        // One-cycle glitch.
        exp_q.push_back({1'b0, 4'd1});
        do_start();
        pulse(1);
        wait_done(20, cyc);
        tick(2);

        // start during MEASURE is ignored: no re-arm after DONE.
        exp_q.push_back({1'b0, 4'd6});
        do_start();
        bus.sig_in = 1'b1;
        tick(4);
        check("t5_in_measure", int'(state_dbg), int'(MEASURE));
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
        tick(1);
        bus.sig_in = 1'b0;
        wait_done(20, cyc);
        tick(1);
        check("t5_no_rearm_busy", int'(bus.busy), 0);
        check("t5_no_rearm_state", int'(state_dbg), int'(IDLE));
        tick(2);

`ifdef PULSE_WIDTH_METER_TIMEOUT_EN
        // Timeout: no rise within MAX_N cycles of ARM entry.
        exp_q.push_back({1'b1, 4'd0});
        do_start();
        check("t6_busy_armed", int'(bus.busy), 1);
        wait_done(30, cyc);
        check("t6_timeout_cycles", cyc, MAX_N);
        tick(2);
`else
        // No timeout: ARM waits indefinitely.
        do_start();
        busy_drops = 0;
        for (int i = 0; i < 100; i++) begin
            if (!bus.busy) busy_drops++;
            tick(1);
        end
        check("t6_busy_held", busy_drops, 0);
        check("t6_still_arm", int'(state_dbg), int'(ARM));
        rst = 1'b0;
        tick(2);
        rst = 1'b1;
        tick(2);
`endif

        tick(3);
        check("queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
